// File: rtl/ddr_wr_arbiter_rr.sv
// N-channel DDR write arbiter: grants one peripheral at a time (fixed priority or round-robin)
// and issues a single AXI4 write burst of BURST_NUM+1 beats on its behalf.
module ddr_wr_arbiter_rr #(
    parameter int unsigned DEVICE_NUM      = 4,
    parameter int unsigned MEM_DQ_WIDTH    = 16,
    parameter int unsigned BURST_LENGTH    = 8,
    parameter int unsigned CTRL_ADDR_WIDTH = 28,
    parameter int unsigned BURST_WIDTH     = 4,
    parameter int unsigned BURST_NUM       = 15,
    parameter int unsigned ARB_MODE        = 1,
    localparam int unsigned DATA_W         = MEM_DQ_WIDTH * BURST_LENGTH
) (
    input  logic                                  i_clk,
    input  logic                                  i_rstn,
    input  logic                                  i_init_ack,
    input  logic [DEVICE_NUM-1:0]                 i_ch_en,
    input  logic [DEVICE_NUM-1:0]                 i_mbus_wrq,
    input  logic [DEVICE_NUM*CTRL_ADDR_WIDTH-1:0] i_mbus_waddr,
    input  logic [DEVICE_NUM*DATA_W-1:0]          i_mbus_wdata,
    input  logic [DEVICE_NUM-1:0]                 i_mbus_wready,
    output logic                                  o_mbus_wdata_rq,
    output logic                                  o_mbus_wbusy,
    output logic [DEVICE_NUM-1:0]                 o_mbus_wsel,
    output logic [CTRL_ADDR_WIDTH-1:0]            o_axi_awaddr,
    output logic [BURST_WIDTH-1:0]                o_axi_awlen,
    output logic                                  o_axi_awvalid,
    input  logic                                  i_axi_awready,
    output logic [DATA_W-1:0]                     o_axi_wdata,
    output logic [DATA_W/8-1:0]                   o_axi_wstrb,
    output logic                                  o_axi_wlast,
    output logic                                  o_axi_wvalid,
    input  logic                                  i_axi_wready
);
    localparam int unsigned IDX_W = (DEVICE_NUM > 1) ? $clog2(DEVICE_NUM) : 1;
    localparam logic [DEVICE_NUM-1:0] ONE_HOT0 = DEVICE_NUM'(1);

    typedef enum logic [1:0] {StIdle, StAw, StW, StDone} state_e;

    state_e                     state_q, state_d;
    logic [IDX_W-1:0]           gnt_q, last_q, pick;
    logic [CTRL_ADDR_WIDTH-1:0] awaddr_q;
    logic [DEVICE_NUM-1:0]      wsel_q, elig;
    logic                       wbusy_q, wdata_rq_q;
    logic [BURST_WIDTH-1:0]     beat_q;
    logic                       in_w, aw_hs, w_hs, grant;

    assign elig  = i_mbus_wrq & i_ch_en;
    assign grant = (state_q == StIdle) && i_init_ack && (|elig);

    always_comb begin
        int   k;
        logic found;
        pick  = '0;
        k     = 0;
        found = 1'b0;
        if (ARB_MODE == 0) begin
            for (int i = int'(DEVICE_NUM) - 1; i >= 0; i--) begin
                if (elig[i]) pick = IDX_W'(i);
            end
        end else begin
            // Scan starts just after the last served channel, wrapping at DEVICE_NUM.
            for (int i = 0; i < int'(DEVICE_NUM); i++) begin
                k = int'(last_q) + 1 + i;
                if (k >= int'(DEVICE_NUM)) k = k - int'(DEVICE_NUM);
                if (!found && elig[k]) begin
                    pick  = IDX_W'(k);
                    found = 1'b1;
                end
            end
        end
    end

    assign in_w            = (state_q == StW);
    assign o_axi_awvalid   = (state_q == StAw);
    assign o_axi_wvalid    = in_w & i_mbus_wready[gnt_q];
    assign o_axi_wdata     = in_w ? i_mbus_wdata[gnt_q*DATA_W +: DATA_W] : '0;
    assign o_axi_wlast     = in_w && (beat_q == BURST_WIDTH'(BURST_NUM));
    assign o_axi_awlen     = BURST_WIDTH'(BURST_NUM);
    assign o_axi_wstrb     = '1;
    assign o_axi_awaddr    = awaddr_q;
    assign o_mbus_wsel     = wsel_q;
    assign o_mbus_wbusy    = wbusy_q;
    assign o_mbus_wdata_rq = wdata_rq_q;
    assign aw_hs           = o_axi_awvalid & i_axi_awready;
    assign w_hs            = o_axi_wvalid & i_axi_wready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (grant) state_d = StAw;
            StAw:    if (aw_hs) state_d = StW;
            StW:     if (w_hs && o_axi_wlast) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= StIdle;
            gnt_q      <= '0;
            last_q     <= IDX_W'(DEVICE_NUM - 1);
            awaddr_q   <= '0;
            wsel_q     <= '0;
            wbusy_q    <= 1'b0;
            wdata_rq_q <= 1'b0;
            beat_q     <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                gnt_q    <= pick;
                awaddr_q <= i_mbus_waddr[pick*CTRL_ADDR_WIDTH +: CTRL_ADDR_WIDTH];
                wsel_q   <= ONE_HOT0 << pick;
                wbusy_q  <= 1'b1;
            end
            if (aw_hs) begin
                beat_q     <= '0;
                wdata_rq_q <= 1'b1;
            end
            if (w_hs) beat_q <= beat_q + BURST_WIDTH'(1);
            if (state_q == StDone) begin
                wdata_rq_q <= 1'b0;
                wsel_q     <= '0;
                wbusy_q    <= 1'b0;
                last_q     <= gnt_q;
            end
        end
    end
endmodule
